// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster timing constants and coordinate types for the
// display path.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

endpackage

// File: rtl/sprite_pos_latch.sv
// Holds a posted sprite position in a shadow register and commits it to the
// renderers only at the start of vertical blanking, so sprites never tear.
module sprite_pos_latch
  import vga_pkg::*;
(
  input  logic vga_clk,
  input  logic reset,
  input  pos_t pos_in,
  input  logic pos_valid,
  input  logic vblank_start,
  output logic pos_pending,
  output pos_t pos_out
);

  pos_t shadow;

  // vblank_start here is the decode that is true on the commit edge itself;
  // a strobe on that same edge skips the shadow and lands directly in pos_out.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      shadow      <= '0;
      pos_out     <= '0;
      pos_pending <= 1'b0;
    end else if (vblank_start) begin
      pos_pending <= 1'b0;
      if (pos_valid) begin
        pos_out <= pos_in;
      end else if (pos_pending) begin
        pos_out <= shadow;
      end
    end else if (pos_valid) begin
      shadow      <= pos_in;
      pos_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter and sync decode for the VGA display path; every output is
// registered from the previous cycle's counters so all of them move together.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic [9:0] pos_x_in,
  input  logic [9:0] pos_y_in,
  input  logic       pos_valid,
  output logic       pos_pending,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       vblank_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_VISIBLE);
  localparam coord_t V_ACT    = coord_t'(V_VISIBLE);
  localparam coord_t HS_FIRST = coord_t'(H_SYNC_START);
  localparam coord_t HS_END   = coord_t'(H_SYNC_END);
  localparam coord_t VS_FIRST = coord_t'(V_SYNC_START);
  localparam coord_t VS_END   = coord_t'(V_SYNC_END);

  coord_t h_cnt;
  coord_t v_cnt;
  logic   at_vblank;
  pos_t   req_pos;
  pos_t   ryu_pos;

  assign at_vblank = (h_cnt == '0) && (v_cnt == V_ACT);

  // Counters advance and the outputs capture the pre-advance counter values
  // on the same edge, giving exactly one cycle of latency for everything.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      DrawX        <= '0;
      DrawY        <= '0;
      blank        <= 1'b0;
      hs           <= 1'b1;
      vs           <= 1'b1;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
      frame_count  <= '0;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
      DrawX        <= h_cnt;
      DrawY        <= v_cnt;
      blank        <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs           <= !((h_cnt >= HS_FIRST) && (h_cnt < HS_END));
      vs           <= !((v_cnt >= VS_FIRST) && (v_cnt < VS_END));
      frame_start  <= (h_cnt == '0) && (v_cnt == '0);
      vblank_start <= at_vblank;
      if (at_vblank) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  assign req_pos.x = pos_x_in;
  assign req_pos.y = pos_y_in;

  sprite_pos_latch u_latch (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .pos_in       (req_pos),
    .pos_valid    (pos_valid),
    .vblank_start (at_vblank),
    .pos_pending  (pos_pending),
    .pos_out      (ryu_pos)
  );

  assign RyuX = ryu_pos.x;
  assign RyuY = ryu_pos.y;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a
// shrunken-raster instance for frame, handshake and reset behaviour.
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic   clk = 1'b0;
  logic   reset_d, reset_s;
  logic   pos_valid;
  coord_t pos_x, pos_y;

  always #20 clk = ~clk;

  logic       d_pending, d_blank, d_hs, d_vs, d_fs, d_vb;
  logic [9:0] d_RyuX, d_RyuY, d_DrawX, d_DrawY;
  logic [7:0] d_fc;

  logic       s_pending, s_blank, s_hs, s_vs, s_frame_start, s_vblank_start;
  logic [9:0] s_RyuX, s_RyuY, s_DrawX, s_DrawY;
  logic [7:0] s_frame_count;

  vga_timing_gen dut_full (
    .vga_clk(clk), .reset(reset_d), .pos_x_in(10'd0), .pos_y_in(10'd0),
    .pos_valid(1'b0), .pos_pending(d_pending), .RyuX(d_RyuX), .RyuY(d_RyuY),
    .DrawX(d_DrawX), .DrawY(d_DrawY), .blank(d_blank), .hs(d_hs), .vs(d_vs),
    .frame_start(d_fs), .vblank_start(d_vb), .frame_count(d_fc)
  );

  // Small raster: H 8+2+3+2 = 15 clocks, V 6+1+2+2 = 11 lines, 165 clocks/frame.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_small (
    .vga_clk(clk), .reset(reset_s), .pos_x_in(pos_x), .pos_y_in(pos_y),
    .pos_valid(pos_valid), .pos_pending(s_pending), .RyuX(s_RyuX), .RyuY(s_RyuY),
    .DrawX(s_DrawX), .DrawY(s_DrawY), .blank(s_blank), .hs(s_hs), .vs(s_vs),
    .frame_start(s_frame_start), .vblank_start(s_vblank_start),
    .frame_count(s_frame_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input int x, input int y);
    pos_valid = v;
    pos_x     = coord_t'(x);
    pos_y     = coord_t'(y);
  endtask

  task automatic waitPos(input int x, input int y, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_DrawX == 10'(x) && s_DrawY == 10'(y)) && n < 400);
    if (!(s_DrawX == 10'(x) && s_DrawY == 10'(y)))
      checkOutput({"timeout_", tag}, 0, 1);
  endtask

  // Expected line timing of the full-size instance, keyed by edge count
  // since reset release (edge n shows the pixel at column n-1).
  typedef struct {
    int   edge_n;
    int   x;
    int   y;
    logic blank;
    logic hs;
    logic vs;
    logic fs;
  } dvec_t;

  dvec_t dq[$];
  int    dcyc   = 0;
  int    hsLowD = 0;
  int    blankD = 0;

  always begin
    dvec_t cur;
    @(posedge clk);
    #2;
    if (reset_d) begin
      dcyc = 0;
    end else begin
      dcyc++;
      if (dcyc <= 800) begin
        if (!d_hs) hsLowD++;
        if (d_blank) blankD++;
      end
      if (dq.size() > 0 && dq[0].edge_n == dcyc) begin
        cur = dq.pop_front();
        checkOutput($sformatf("full_e%0d_DrawX", dcyc), d_DrawX, cur.x);
        checkOutput($sformatf("full_e%0d_DrawY", dcyc), d_DrawY, cur.y);
        checkOutput($sformatf("full_e%0d_blank", dcyc), d_blank, cur.blank);
        checkOutput($sformatf("full_e%0d_hs", dcyc), d_hs, cur.hs);
        checkOutput($sformatf("full_e%0d_vs", dcyc), d_vs, cur.vs);
        checkOutput($sformatf("full_e%0d_frame_start", dcyc), d_fs, cur.fs);
      end
    end
  end

  // Committed-position scoreboard: expected values are pushed when the
  // final strobe of a frame is driven and popped at the next vblank_start.
  pos_t   commitQ[$];
  int     ryuChanges = 0;
  coord_t prevX = '0;
  coord_t prevY = '0;

  always begin
    pos_t exp_pos;
    @(posedge clk);
    #2;
    if (!reset_s) begin
      if (s_vblank_start && commitQ.size() > 0) begin
        exp_pos = commitQ.pop_front();
        checkOutput("commit_RyuX", s_RyuX, exp_pos.x);
        checkOutput("commit_RyuY", s_RyuY, exp_pos.y);
      end
      if (!s_vblank_start && (s_RyuX != prevX || s_RyuY != prevY)) ryuChanges++;
    end
    prevX = s_RyuX;
    prevY = s_RyuY;
  end

  initial begin
    dvec_t tbl[11];
    int cnt, blankN, hsLowN, vsLowN, vsBad, vbN, vbX, vbY, vbFc, fsN, fc0, vbCount;
    bit done;

    tbl = '{
      '{1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1},
      '{2,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0},
      '{640, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0},
      '{641, 640, 0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{656, 655, 0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{657, 656, 0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{752, 751, 0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{753, 752, 0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{800, 799, 0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{801, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0},
      '{802, 1,   1, 1'b1, 1'b1, 1'b1, 1'b0}
    };
    foreach (tbl[i]) dq.push_back(tbl[i]);

    reset_d = 1'b1;
    reset_s = 1'b1;
    applyStimulus(1'b0, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_full_hs", d_hs, 1);
    checkOutput("rst_full_blank", d_blank, 0);
    checkOutput("rst_small_vs", s_vs, 1);
    checkOutput("rst_small_fc", s_frame_count, 0);
    checkOutput("rst_small_pending", s_pending, 0);
    reset_d = 1'b0;
    reset_s = 1'b0;

    @(negedge clk);
    checkOutput("first_DrawX", s_DrawX, 0);
    checkOutput("first_DrawY", s_DrawY, 0);
    checkOutput("first_blank", s_blank, 1);
    checkOutput("first_frame_start", s_frame_start, 1);

    // One full frame of the small raster, starting at the frame_start sample.
    cnt = 0; blankN = 0; hsLowN = 0; vsLowN = 0; vsBad = 0;
    vbN = 0; vbX = -1; vbY = -1; vbFc = -1; fsN = 0;
    fc0 = int'(s_frame_count);
    do begin
      if (s_blank) blankN++;
      if (!s_hs) hsLowN++;
      if (!s_vs) vsLowN++;
      if ((!s_vs) != (s_DrawY == 10'd7 || s_DrawY == 10'd8)) vsBad++;
      if (s_frame_start) fsN++;
      if (s_vblank_start) begin
        vbN++;
        vbX  = int'(s_DrawX);
        vbY  = int'(s_DrawY);
        vbFc = int'(s_frame_count);
        checkOutput("hold_RyuX_no_pending", s_RyuX, 0);
      end
      @(negedge clk);
      cnt++;
    end while (!s_frame_start && cnt < 1000);
    checkOutput("frame_period", cnt, 165);
    checkOutput("blank_high_per_frame", blankN, 48);
    checkOutput("hs_low_per_frame", hsLowN, 33);
    checkOutput("vs_low_per_frame", vsLowN, 30);
    checkOutput("vs_outside_sync_rows", vsBad, 0);
    checkOutput("frame_start_pulses", fsN, 1);
    checkOutput("vblank_pulses", vbN, 1);
    checkOutput("vblank_DrawX", vbX, 0);
    checkOutput("vblank_DrawY", vbY, 6);
    checkOutput("vblank_frame_count", vbFc, fc0 + 1);

    // Single strobe mid-frame: held pending until the commit edge.
    waitPos(0, 2, "t1_strobe");
    applyStimulus(1'b1, 100, 200);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0);
    commitQ.push_back('{x: 10'd100, y: 10'd200});
    checkOutput("t1_pending_set", s_pending, 1);
    checkOutput("t1_RyuX_old", s_RyuX, 0);
    waitPos(14, 5, "t1_pre_vblank");
    checkOutput("t1_RyuY_old", s_RyuY, 0);
    checkOutput("t1_pending_held", s_pending, 1);
    @(negedge clk);
    checkOutput("t1_vblank", s_vblank_start, 1);
    checkOutput("t1_pending_clear", s_pending, 0);

    // Two strobes in one frame: the later one wins.
    waitPos(0, 1, "t2_first");
    applyStimulus(1'b1, 10, 20);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0);
    waitPos(3, 3, "t2_second");
    applyStimulus(1'b1, 30, 40);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0);
    commitQ.push_back('{x: 10'd30, y: 10'd40});
    checkOutput("t2_pending", s_pending, 1);
    checkOutput("t2_RyuX_prev", s_RyuX, 100);
    waitPos(14, 5, "t2_pre_vblank");
    @(negedge clk);
    checkOutput("t2_vblank", s_vblank_start, 1);
    checkOutput("t2_pending_clear", s_pending, 0);

    // Strobe sampled on the commit edge itself bypasses the shadow.
    waitPos(14, 5, "t3_pre_vblank");
    applyStimulus(1'b1, 55, 66);
    commitQ.push_back('{x: 10'd55, y: 10'd66});
    @(negedge clk);
    applyStimulus(1'b0, 0, 0);
    checkOutput("t3_vblank", s_vblank_start, 1);
    checkOutput("t3_RyuX", s_RyuX, 55);
    checkOutput("t3_pending", s_pending, 0);
    @(negedge clk);
    checkOutput("t3_RyuY_after", s_RyuY, 66);
    checkOutput("t3_pending_after", s_pending, 0);

    // Mid-frame reset with a request pending.
    waitPos(2, 3, "t4_strobe");
    applyStimulus(1'b1, 77, 88);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0);
    checkOutput("t4_pending_set", s_pending, 1);
    waitPos(5, 3, "t4_reset_point");
    reset_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t4_rst%0d_hs", i), s_hs, 1);
      checkOutput($sformatf("t4_rst%0d_vs", i), s_vs, 1);
      checkOutput($sformatf("t4_rst%0d_blank", i), s_blank, 0);
      checkOutput($sformatf("t4_rst%0d_RyuX", i), s_RyuX, 0);
      checkOutput($sformatf("t4_rst%0d_RyuY", i), s_RyuY, 0);
      checkOutput($sformatf("t4_rst%0d_pending", i), s_pending, 0);
      checkOutput($sformatf("t4_rst%0d_DrawX", i), s_DrawX, 0);
    end
    reset_s = 1'b0;
    @(negedge clk);
    checkOutput("t4_post_DrawX", s_DrawX, 0);
    checkOutput("t4_post_DrawY", s_DrawY, 0);
    checkOutput("t4_post_frame_start", s_frame_start, 1);
    checkOutput("t4_post_blank", s_blank, 1);

    // frame_count progression from reset through the 255 -> 0 wrap.
    vbCount = 0;
    done = 1'b0;
    for (int n = 0; n < 45000 && !done; n++) begin
      @(negedge clk);
      if (s_vblank_start) begin
        vbCount++;
        if (vbCount == 1) begin
          checkOutput("fc_first", s_frame_count, 1);
          checkOutput("t4_discarded_RyuX", s_RyuX, 0);
          checkOutput("t4_discarded_pending", s_pending, 0);
        end else if (vbCount == 2) begin
          checkOutput("fc_second", s_frame_count, 2);
        end else if (vbCount == 255) begin
          checkOutput("fc_255", s_frame_count, 255);
        end else if (vbCount == 256) begin
          checkOutput("fc_wrap", s_frame_count, 0);
          done = 1'b1;
        end
      end
    end
    if (!done) checkOutput("fc_wrap_timeout", 0, 1);

    checkOutput("full_table_left", dq.size(), 0);
    checkOutput("full_hs_low_line0", hsLowD, 96);
    checkOutput("full_blank_high_line0", blankD, 640);
    checkOutput("ryu_changes_off_vblank", ryuChanges, 0);
    checkOutput("commit_queue_left", commitQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
